// File: rtl/sign_narrow_pkg.sv
// rtl/sign_narrow_pkg.sv - shared widths, saturation constants and state type for sign_narrow
package sign_narrow_pkg;

    localparam int IN_W_DEF  = 32;
    localparam int OUT_W_DEF = 6;
    localparam int CNT_W_DEF = 16;

    // Most-positive signed pattern of width w (0111...1), right-aligned in 64 bits
    function automatic logic [63:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most-negative signed pattern of width w (1000...0), right-aligned in 64 bits
    function automatic logic [63:0] sat_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

    localparam logic [OUT_W_DEF-1:0] SAT_POS = OUT_W_DEF'(sat_pos(OUT_W_DEF));
    localparam logic [OUT_W_DEF-1:0] SAT_NEG = OUT_W_DEF'(sat_neg(OUT_W_DEF));

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/sign_narrow_if.sv
// rtl/sign_narrow_if.sv - input/output stream and counter signals of sign_narrow
interface sign_narrow_if
    import sign_narrow_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic             clr_count;
    logic [CNT_W-1:0] ovf_count;

    modport master (
        output in_valid, in_data, sat_en, out_ready, clr_count,
        input  in_ready, out_valid, out_data, out_ovf, ovf_count
    );

    modport slave (
        input  in_valid, in_data, sat_en, out_ready, clr_count,
        output in_ready, out_valid, out_data, out_ovf, ovf_count
    );

endinterface

// File: rtl/sign_narrow_fits_signed.sv
// rtl/sign_narrow_fits_signed.sv - checks whether a signed word fits in OUT_W signed bits
module fits_signed
    import sign_narrow_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [IN_W-1:0] data,
    output logic            fits,
    output logic            sign
);

    // The word fits exactly when sign-extending its low OUT_W bits rebuilds it,
    // i.e. bits [IN_W-1:OUT_W-1] are all copies of one value.
    assign fits = (data == {{(IN_W-OUT_W){data[OUT_W-1]}}, data[OUT_W-1:0]});
    assign sign = data[IN_W-1];

endmodule

// File: rtl/sign_narrow.sv
// rtl/sign_narrow.sv - narrows signed words to OUT_W bits with saturate/wrap and overflow count
module sign_narrow
    import sign_narrow_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    sign_narrow_if.slave  bus
);

    localparam logic [OUT_W-1:0] SAT_POS_W = OUT_W'(sat_pos(OUT_W));
    localparam logic [OUT_W-1:0] SAT_NEG_W = OUT_W'(sat_neg(OUT_W));
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [IN_W-1:0]  in_data;
    logic             fits;
    logic             sign;
    logic             in_ready;
    logic             in_xfer;
    state_t           state;
    state_t           state_next;
    logic [OUT_W-1:0] narrowed;
    logic [OUT_W-1:0] out_data_q;
    logic             out_ovf_q;
    logic [CNT_W-1:0] ovf_count_q;

    assign in_data = bus.in_data;

    fits_signed #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_fits (
        .data (in_data),
        .fits (fits),
        .sign (sign)
    );

    // The single output register can take a new word when empty or being drained this cycle
    assign in_ready = (state == ST_EMPTY) || bus.out_ready;
    assign in_xfer  = bus.in_valid && in_ready;

    // Narrowed value: keep the low bits unless an overflow must be clamped
    always_comb begin
        narrowed = in_data[OUT_W-1:0];
        if (!fits && bus.sat_en) begin
            narrowed = sign ? SAT_NEG_W : SAT_POS_W;
        end
    end

    // Output register occupancy state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy transitions: fill on accept, empty on drain without refill
    always_comb begin
        state_next = state;
        unique case (state)
            ST_EMPTY: if (in_xfer) state_next = ST_FULL;
            ST_FULL:  if (!in_xfer && bus.out_ready) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // Interface outputs driven from occupancy state and held registers
    always_comb begin
        bus.out_valid = (state == ST_FULL);
        bus.in_ready  = in_ready;
        bus.out_data  = out_data_q;
        bus.out_ovf   = out_ovf_q;
        bus.ovf_count = ovf_count_q;
    end

    // Capture the narrowed word and its overflow flag on every accepted input
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else if (in_xfer) begin
            out_data_q <= narrowed;
            out_ovf_q  <= !fits;
        end
    end

    // Saturating overflow counter; clear has priority over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count_q <= '0;
        end else if (bus.clr_count) begin
            ovf_count_q <= '0;
        end else if (in_xfer && !fits && (ovf_count_q != CNT_MAX)) begin
            ovf_count_q <= ovf_count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_sign_narrow.sv
// tb/tb_sign_narrow.sv - scoreboard bench for sign_narrow with directed vectors
module tb_sign_narrow;
    import sign_narrow_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sign_narrow_if #(.IN_W(IN_W_DEF), .OUT_W(OUT_W_DEF), .CNT_W(CNT_W_DEF)) bus ();

    sign_narrow #(.IN_W(IN_W_DEF), .OUT_W(OUT_W_DEF), .CNT_W(CNT_W_DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [5:0] d;
        logic       o;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_cnt = 16'd0;

    // Directed vectors: input word, sat_en, hand-computed out_data, out_ovf
    logic [31:0] v_data [13] = '{32'hFFFFFFE0, 32'h00000020, 32'h00000020, 32'h80000000,
                                 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 32'h00000000,
                                 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFDF, 32'hFFFFFFDF,
                                 32'h00000045};
    logic        v_sat  [13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [5:0]  v_exp  [13] = '{6'h20, 6'h1F, 6'h20, 6'h20, 6'h00, 6'h1F, 6'h3F, 6'h00,
                                 6'h3F, 6'h1F, 6'h20, 6'h1F, 6'h05};
    logic        v_ovf  [13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus, entered and left at posedge+1; records accepted words
    task automatic step(input logic v, input logic [31:0] d, input logic s, input logic ordy,
                        input logic clr, input logic [5:0] ed, input logic eo, output logic acc);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.sat_en    = s;
        bus.out_ready = ordy;
        bus.clr_count = clr;
        @(negedge clk);
        acc = v && bus.in_ready && !rst;
        if (acc) sb.push_back('{d: ed, o: eo});
        if (!rst) begin
            if (clr) model_cnt = 16'd0;
            else if (acc && eo && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability
    initial begin : monitor
        logic       prev_stall;
        logic [5:0] prev_d;
        logic       prev_o;
        exp_t       e;
        prev_stall = 1'b0;
        prev_d     = 6'd0;
        prev_o     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_data", 32'(bus.out_data), 32'(prev_d));
                    chk("hold_ovf", 32'(bus.out_ovf), 32'(prev_o));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=0x%0h required=none", bus.out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 32'(bus.out_data), 32'(e.d));
                        chk("out_ovf", 32'(bus.out_ovf), 32'(e.o));
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_d     = bus.out_data;
                prev_o     = bus.out_ovf;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic acc;
        int   idx;
        int   guard;
        logic ordy;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.sat_en    = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_count = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        chk("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
        rst = 1'b0;
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // All vectors, downstream always ready
        for (int i = 0; i < 13; i++) begin
            step(1'b1, v_data[i], v_sat[i], 1'b1, 1'b0, v_exp[i], v_ovf[i], acc);
            chk("accept_phase1", 32'(acc), 32'd1);
        end
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, acc);
        chk("cnt_phase1", 32'(bus.ovf_count), 32'd9);
        chk("cnt_model1", 32'(bus.ovf_count), 32'(model_cnt));

        // Eight words with out_ready toggling every cycle
        idx   = 0;
        guard = 0;
        ordy  = 1'b1;
        while (idx < 8 && guard < 100) begin
            step(1'b1, v_data[idx], v_sat[idx], ordy, 1'b0, v_exp[idx], v_ovf[idx], acc);
            if (acc) idx++;
            ordy = ~ordy;
            guard++;
        end
        chk("toggle_all_sent", 32'(idx), 32'd8);
        repeat (3) step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, acc);
        chk("sb_empty_toggle", 32'(sb.size()), 32'd0);
        chk("cnt_phase2", 32'(bus.ovf_count), 32'd13);

        // Counter saturation and clear priority
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, acc);
        chk("cnt_cleared", 32'(bus.ovf_count), 32'd0);
        repeat (65534) step(1'b1, 32'h00000020, 1'b1, 1'b1, 1'b0, SAT_POS, 1'b1, acc);
        chk("cnt_preload", 32'(bus.ovf_count), 32'hFFFE);
        step(1'b1, 32'h00000020, 1'b1, 1'b1, 1'b0, SAT_POS, 1'b1, acc);
        chk("cnt_max", 32'(bus.ovf_count), 32'hFFFF);
        step(1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, SAT_NEG, 1'b1, acc);
        chk("cnt_sticks", 32'(bus.ovf_count), 32'hFFFF);
        step(1'b1, 32'h00000020, 1'b0, 1'b1, 1'b1, 6'h20, 1'b1, acc);
        chk("cnt_clr_wins", 32'(bus.ovf_count), 32'd0);
        chk("cnt_model3", 32'(bus.ovf_count), 32'(model_cnt));
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, acc);

        // Reset while FULL and stalled discards the held word
        step(1'b1, 32'h00000045, 1'b0, 1'b0, 1'b0, 6'h05, 1'b1, acc);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, acc);
        chk("full_before_rst", 32'(bus.out_valid), 32'd1);
        chk("cnt_before_rst", 32'(bus.ovf_count), 32'd1);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h00000040;
        @(posedge clk);
        #1;
        sb.delete();
        model_cnt = 16'd0;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_data", 32'(bus.out_data), 32'd0);
        chk("midrst_out_ovf", 32'(bus.out_ovf), 32'd0);
        chk("midrst_ovf_count", 32'(bus.ovf_count), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        step(1'b1, 32'h00000040, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, acc);
        rst = 1'b0;
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, acc);
        chk("no_xfer_in_rst", 32'(bus.out_valid), 32'd0);
        chk("no_cnt_in_rst", 32'(bus.ovf_count), 32'd0);

        // Normal operation resumes after reset
        step(1'b1, 32'hFFFFFFE0, 1'b0, 1'b1, 1'b0, 6'h20, 1'b0, acc);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        repeat (2) step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, acc);
        chk("sb_empty_final", 32'(sb.size()), 32'd0);
        chk("cnt_final", 32'(bus.ovf_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
